// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: moves one word per cycle between data_memory and the RF for each mask bit.
// Latency: N=popcount(mask) RUN cycles, done in cycle N+1; holds busy (pipeline stall) until back in IDLE.
module lm_sm_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        reg_mask_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_access_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_en_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_read_data_i,
    output logic [2:0]        rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic              rf_wr_en_o,
    output logic [2:0]        rf_wr_addr_o,
    output logic [DATA_W-1:0] rf_wr_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                is_store_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          mask_q;
    logic                wb_pend_q;
    logic [2:0]          wb_idx_q;
    logic [DATA_W-1:0]   wb_data_q;

    logic [2:0]          idx;
    logic [7:0]          mask_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                run;

    // Lowest set bit of the remaining mask selects the register serviced this cycle.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign mask_d = mask_q & (mask_q - 8'd1);
    assign addr_d = addr_q + ADDR_W'(ADDR_STEP);
    assign run    = (state_q == S_RUN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            mask_q     <= '0;
            wb_pend_q  <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        is_store_q <= is_store_i;
                        addr_q     <= base_addr_i;
                        mask_q     <= reg_mask_i;
                        state_q    <= (reg_mask_i != 8'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        mask_q  <= '0;
                    end else begin
                        mask_q <= mask_d;
                        addr_q <= addr_d;
                        if (!is_store_q) begin
                            wb_pend_q <= 1'b1;
                            wb_idx_q  <= idx;
                            wb_data_q <= mem_read_data_i;
                        end
                        if (mask_d == 8'd0) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory and RF ports are same-cycle paths, so they decode directly from the registered state.
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = (state_q == S_DONE) && !flush_i;
    assign mem_access_addr_o = run ? addr_q : '0;
    assign mem_read_o        = run && !is_store_q && !flush_i;
    assign mem_write_en_o    = run && is_store_q && !flush_i;
    assign mem_write_data_o  = (run && is_store_q) ? rf_rd_data_i : '0;
    assign rf_rd_addr_o      = run ? idx : 3'd0;
    assign rf_wr_en_o        = wb_pend_q && !flush_i;
    assign rf_wr_addr_o      = wb_pend_q ? wb_idx_q : 3'd0;
    assign rf_wr_data_o      = wb_pend_q ? wb_data_q : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with a behavioural data_memory (8-bit index) and register file.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        flush;
    logic        busy;
    logic        done;
    logic [15:0] mem_access_addr;
    logic        mem_read;
    logic        mem_write_en;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;

    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:7];
    logic        ld_en;
    logic        ld_rf;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer #(.ADDR_W(16), .DATA_W(16), .ADDR_STEP(1)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .start_i           (start),
        .is_store_i        (is_store),
        .base_addr_i       (base_addr),
        .reg_mask_i        (reg_mask),
        .flush_i           (flush),
        .busy_o            (busy),
        .done_o            (done),
        .mem_access_addr_o (mem_access_addr),
        .mem_read_o        (mem_read),
        .mem_write_en_o    (mem_write_en),
        .mem_write_data_o  (mem_write_data),
        .mem_read_data_i   (mem_read_data),
        .rf_rd_addr_o      (rf_rd_addr),
        .rf_rd_data_i      (rf_rd_data),
        .rf_wr_en_o        (rf_wr_en),
        .rf_wr_addr_o      (rf_wr_addr),
        .rf_wr_data_o      (rf_wr_data)
    );

    assign mem_read_data = mem[mem_access_addr[7:0]];
    assign rf_rd_data    = rf[rf_rd_addr];

    always @(posedge clk) begin
        if (ld_en && !ld_rf) mem[ld_addr] <= ld_data;
        else if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
        if (ld_en && ld_rf) rf[ld_addr[2:0]] <= ld_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are updated.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic to_rf, input logic [7:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_rf   = to_rf;
        ld_addr = a;
        ld_data = d;
        nxt();
        ld_en   = 1'b0;
    endtask

    task automatic go(input logic st, input logic [15:0] base, input logic [7:0] mask);
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        reg_mask  = mask;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
        flush = 1'b0; ld_en = 1'b0; ld_rf = 1'b0; ld_addr = '0; ld_data = '0;
        nxt();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_rd", 32'(mem_read), 0);
        chk("rst_mem_we", 32'(mem_write_en), 0);
        chk("rst_rf_we", 32'(rf_wr_en), 0);
        chk("rst_addr", 32'(mem_access_addr), 0);
        nxt();
        for (int i = 0; i < 8; i++) poke(1'b1, 8'(i), 16'h1000 + 16'(i));
        poke(1'b0, 8'h10, 16'hAAAA);
        poke(1'b0, 8'h11, 16'hBBBB);
        poke(1'b0, 8'h12, 16'hCCCC);
        for (int i = 0; i < 4; i++) poke(1'b0, 8'h40 + 8'(i), 16'h0000);
        poke(1'b0, 8'h20, 16'h2222);
        rst_n = 1'b1;
        nxt();

        // SM, full mask, address crosses the 8-bit RAM index boundary
        go(1'b1, 16'h00FE, 8'hFF);
        #2 chk("sm_c0_busy", 32'(busy), 0);
        for (int c = 1; c <= 8; c++) begin
            nxt();
            start = 1'b0; base_addr = 16'h0000; reg_mask = 8'h00;
            #2;
            chk("sm_we", 32'(mem_write_en), 1);
            chk("sm_addr", 32'(mem_access_addr), 32'(16'h00FE + 16'(c - 1)));
            chk("sm_wdata", 32'(mem_write_data), 32'(16'h1000 + 16'(c - 1)));
            chk("sm_rd", 32'(mem_read), 0);
            chk("sm_done_early", 32'(done), 0);
        end
        nxt(); #2;
        chk("sm_c9_done", 32'(done), 1);
        chk("sm_c9_we", 32'(mem_write_en), 0);
        nxt(); #2;
        chk("sm_c10_busy", 32'(busy), 0);
        chk("sm_mem_fe", 32'(mem[8'hFE]), 'h1000);
        chk("sm_mem_00", 32'(mem[8'h00]), 'h1002);
        chk("sm_mem_05", 32'(mem[8'h05]), 'h1007);

        // SM aborted by flush in cycle 2
        nxt();
        go(1'b1, 16'h0040, 8'h0F);
        nxt(); start = 1'b0; #2;
        chk("fl_c1_we", 32'(mem_write_en), 1);
        chk("fl_c1_addr", 32'(mem_access_addr), 'h40);
        nxt(); flush = 1'b1; #2;
        chk("fl_c2_we", 32'(mem_write_en), 0);
        chk("fl_c2_done", 32'(done), 0);
        nxt(); flush = 1'b0; #2;
        chk("fl_c3_busy", 32'(busy), 0);
        chk("fl_c3_done", 32'(done), 0);
        chk("fl_mem40", 32'(mem[8'h40]), 'h1000);
        chk("fl_mem41", 32'(mem[8'h41]), 'h0000);

        // LM mask 0x85 with base/mask changed after start
        nxt();
        go(1'b0, 16'h0010, 8'h85);
        #2 chk("lm_c0_busy", 32'(busy), 0);
        nxt(); start = 1'b0; base_addr = 16'h0077; reg_mask = 8'hFF; #2;
        chk("lm_c1_busy", 32'(busy), 1);
        chk("lm_c1_rd", 32'(mem_read), 1);
        chk("lm_c1_addr", 32'(mem_access_addr), 'h10);
        chk("lm_c1_rfra", 32'(rf_rd_addr), 0);
        chk("lm_c1_rfwe", 32'(rf_wr_en), 0);
        nxt(); #2;
        chk("lm_c2_addr", 32'(mem_access_addr), 'h11);
        chk("lm_c2_rfwe", 32'(rf_wr_en), 1);
        chk("lm_c2_rfwa", 32'(rf_wr_addr), 0);
        chk("lm_c2_rfwd", 32'(rf_wr_data), 'hAAAA);
        chk("lm_c2_done", 32'(done), 0);
        nxt(); #2;
        chk("lm_c3_addr", 32'(mem_access_addr), 'h12);
        chk("lm_c3_rfwa", 32'(rf_wr_addr), 2);
        chk("lm_c3_rfwd", 32'(rf_wr_data), 'hBBBB);
        nxt(); #2;
        chk("lm_c4_done", 32'(done), 1);
        chk("lm_c4_busy", 32'(busy), 1);
        chk("lm_c4_rd", 32'(mem_read), 0);
        chk("lm_c4_rfwe", 32'(rf_wr_en), 1);
        chk("lm_c4_rfwa", 32'(rf_wr_addr), 7);
        chk("lm_c4_rfwd", 32'(rf_wr_data), 'hCCCC);
        nxt(); #2;
        chk("lm_c5_busy", 32'(busy), 0);
        chk("lm_c5_done", 32'(done), 0);
        chk("lm_r0", 32'(rf[0]), 'hAAAA);
        chk("lm_r2", 32'(rf[2]), 'hBBBB);
        chk("lm_r7", 32'(rf[7]), 'hCCCC);
        chk("lm_r1", 32'(rf[1]), 'h1001);

        // Empty mask, LM then SM
        go(1'b0, 16'h0010, 8'h00);
        nxt(); start = 1'b0; #2;
        chk("m0l_done", 32'(done), 1);
        chk("m0l_busy", 32'(busy), 1);
        chk("m0l_rd", 32'(mem_read), 0);
        chk("m0l_rfwe", 32'(rf_wr_en), 0);
        nxt(); #2;
        chk("m0l_c2_busy", 32'(busy), 0);
        chk("m0l_c2_done", 32'(done), 0);
        go(1'b1, 16'h0010, 8'h00);
        nxt(); start = 1'b0; #2;
        chk("m0s_done", 32'(done), 1);
        chk("m0s_we", 32'(mem_write_en), 0);
        nxt(); #2;
        chk("m0s_c2_busy", 32'(busy), 0);

        // LM interrupted by reset in cycle 2, then a fresh transfer
        go(1'b0, 16'h0020, 8'hF0);
        nxt(); start = 1'b0; #2;
        chk("rs_c1_rd", 32'(mem_read), 1);
        chk("rs_c1_rfra", 32'(rf_rd_addr), 4);
        nxt(); rst_n = 1'b0; #2;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_rd", 32'(mem_read), 0);
        chk("rs_rfwe", 32'(rf_wr_en), 0);
        chk("rs_rfwd", 32'(rf_wr_data), 0);
        chk("rs_addr", 32'(mem_access_addr), 0);
        nxt();
        nxt(); rst_n = 1'b1; #2;
        chk("rs_rel_busy", 32'(busy), 0);
        chk("rs_r4", 32'(rf[4]), 'h1004);
        chk("rs_r5", 32'(rf[5]), 'h1005);
        chk("rs_r6", 32'(rf[6]), 'h1006);
        chk("rs_r7", 32'(rf[7]), 'hCCCC);
        nxt();
        go(1'b0, 16'h0020, 8'h02);
        nxt(); start = 1'b0; #2;
        chk("rs2_rd", 32'(mem_read), 1);
        chk("rs2_rfra", 32'(rf_rd_addr), 1);
        nxt(); #2;
        chk("rs2_done", 32'(done), 1);
        chk("rs2_rfwa", 32'(rf_wr_addr), 1);
        chk("rs2_rfwd", 32'(rf_wr_data), 'h2222);
        nxt(); #2;
        chk("rs2_r1", 32'(rf[1]), 'h2222);
        chk("rs2_busy", 32'(busy), 0);

        // Address wrap, start ignored while busy, start+flush in IDLE
        poke(1'b0, 8'hFF, 16'h0F0F);
        poke(1'b0, 8'h00, 16'h0A0A);
        go(1'b0, 16'hFFFF, 8'h03);
        nxt(); go(1'b1, 16'h0000, 8'hFF); #2;
        chk("wr_c1_addr", 32'(mem_access_addr), 'hFFFF);
        chk("wr_c1_rd", 32'(mem_read), 1);
        nxt(); start = 1'b0; #2;
        chk("wr_c2_addr", 32'(mem_access_addr), 'h0000);
        chk("wr_c2_rfwd", 32'(rf_wr_data), 'h0F0F);
        nxt(); #2;
        chk("wr_c3_done", 32'(done), 1);
        chk("wr_c3_rfwd", 32'(rf_wr_data), 'h0A0A);
        chk("wr_c3_we", 32'(mem_write_en), 0);
        nxt(); #2;
        chk("wr_c4_busy", 32'(busy), 0);
        go(1'b1, 16'h0040, 8'h01);
        flush = 1'b1;
        nxt(); start = 1'b0; flush = 1'b0; #2;
        chk("sf_busy", 32'(busy), 0);
        chk("sf_we", 32'(mem_write_en), 0);
        nxt(); #2;
        chk("sf_done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
